reg_writeback_arb: RTL and testbench
====================================

// Module: reg_writeback_arb
// PURPOSE
//  Write-side front end for the dual-read/single-write pipelined register file.
//  Merges a single-cycle ALU result stream with a multi-cycle result stream from
//  load/mul/div, buffering the latter in a small FIFO. Drives the file's single
//  write port (c_reg/c_writedatain/c_we). Reports per-read-port pending-write
//  status, because the file returns OLD_DATA on same-cycle read/write collision.
// PARAMETERS
//  WIDTH        32  data width of a register
//  LOG2NUMREGS   5  register index width (32 registers)
//  DEPTH         4  slow-result FIFO entries (power of 2)
//  LOG2DEPTH     2  log2(DEPTH)
// PORTS
//  clk            in   1            clock
//  resetn         in   1            synchronous reset, active low
//  alu_we         in   1            ALU result valid; always accepted
//  alu_reg        in   LOG2NUMREGS  ALU destination register
//  alu_data       in   WIDTH        ALU result
//  mem_valid      in   1            slow result valid
//  mem_reg        in   LOG2NUMREGS  slow destination register
//  mem_data       in   WIDTH        slow result
//  mem_ready      out  1            slow result accepted when mem_valid&mem_ready
//  c_reg          out  LOG2NUMREGS  register-file write address (registered)
//  c_writedatain  out  WIDTH        register-file write data (registered)
//  c_we           out  1            register-file write enable (registered)
//  a_reg, b_reg   in   LOG2NUMREGS  addresses being presented to read ports a/b
//  a_pending      out  1            write to a_reg not yet visible in file
//  b_pending      out  1            write to b_reg not yet visible in file
//  fifo_count     out  LOG2DEPTH+1  valid+killed entries held in FIFO
// BEHAVIOUR
//  Reset (resetn=0 at edge): c_we=0, c_reg=0, c_writedatain=0, FIFO emptied,
//   fifo_count=0, all entry valid bits 0. mem_ready=0 while resetn=0, else
//   mem_ready=(fifo_count<DEPTH) from registered count (no same-cycle pop credit).
//  Reset mid-operation discards all buffered writes; no c_we in the cycle after.
//  Register 0 is never written: alu_we/mem accepts with reg==0 are dropped
//   (mem still handshakes). c_we=1 never occurs with c_reg=0.
//  Issue select per cycle, result loaded into c_* at the edge:
//   1) alu_we & alu_reg!=0            -> issue ALU; latency 1 cycle.
//   2) else FIFO head present          -> pop head; c_we=head.valid (killed
//      entries drain with c_we=0, one per cycle).
//   3) else mem accept & reg!=0        -> bypass FIFO, issue directly; latency 1.
//   4) else                            -> c_we=0; c_reg/c_writedatain hold.
//  Enqueue: mem accept not bypassed -> push at tail with valid=1. Push and pop in
//   the same cycle allowed; count unchanged.
//  Ordering: ALU result is program-newer than any outstanding slow result. ALU
//   issue to R clears valid on every FIFO entry with reg==R at the same edge; a
//   mem accept to R in that same cycle is enqueued with valid=0.
//  Pending (combinational from registered state): x_pending=1 iff x_reg!=0 and
//   ((c_we & c_reg==x_reg) or any FIFO entry valid with reg==x_reg). Incoming
//   same-cycle alu/mem inputs are not included (consumer owns that forwarding).
//  Pointers wrap modulo DEPTH; fifo_count ranges 0..DEPTH, never exceeds DEPTH.
// TESTING
//  Reset then alu_we=1,alu_reg=3,alu_data=0xA5 -> next cycle c_we=1,c_reg=3,
//   c_writedatain=0xA5; following cycle c_we=0.
//  mem_valid held with ALU busy 5 cycles, regs 1..5 -> mem_ready drops after 4
//   accepts, fifo_count=4; ALU idle -> 4 writes issue in order regs 1..4, then 5.
//  Enqueue mem r7=0x11, then alu r7=0x22 -> c_we once with r7=0x22; killed entry
//   drains with c_we=0; a_reg=7 a_pending=1 only until the 0x22 write cycle ends.
//  alu_reg=0 or mem_reg=0 with data 0xFFFF -> c_we stays 0, fifo_count stays 0.
//  Fill FIFO to 3 then resetn=0 for one cycle -> fifo_count=0, c_we=0,
//   a_pending=b_pending=0, mem_ready=1 on the first cycle after release.

Source files
------------

// File: rtl/reg_writeback_arb.sv
// Write-port front end for the 2R/1W register file: merges the single-cycle ALU stream
// with buffered multi-cycle results and reports per-read-port pending-write status.
module reg_writeback_arb #(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned LOG2NUMREGS = 5,
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned LOG2DEPTH   = 2
) (
    input  logic                   clk,
    input  logic                   resetn,
    input  logic                   alu_we,
    input  logic [LOG2NUMREGS-1:0] alu_reg,
    input  logic [WIDTH-1:0]       alu_data,
    input  logic                   mem_valid,
    input  logic [LOG2NUMREGS-1:0] mem_reg,
    input  logic [WIDTH-1:0]       mem_data,
    output logic                   mem_ready,
    output logic [LOG2NUMREGS-1:0] c_reg,
    output logic [WIDTH-1:0]       c_writedatain,
    output logic                   c_we,
    input  logic [LOG2NUMREGS-1:0] a_reg,
    input  logic [LOG2NUMREGS-1:0] b_reg,
    output logic                   a_pending,
    output logic                   b_pending,
    output logic [LOG2DEPTH:0]     fifo_count
);

    localparam int unsigned CW = LOG2DEPTH + 1;

    logic [LOG2NUMREGS-1:0] fifo_reg_q  [DEPTH];
    logic [LOG2NUMREGS-1:0] fifo_reg_d  [DEPTH];
    logic [WIDTH-1:0]       fifo_data_q [DEPTH];
    logic [WIDTH-1:0]       fifo_data_d [DEPTH];
    logic [DEPTH-1:0]       fifo_vld_q, fifo_vld_d;
    logic [LOG2DEPTH-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]          count_q, count_d;
    logic [LOG2NUMREGS-1:0] c_reg_q, c_reg_d;
    logic [WIDTH-1:0]       c_data_q, c_data_d;
    logic                   c_we_q, c_we_d;

    logic alu_iss, mem_acc, fifo_ne, pop, bypass, push;

    assign mem_ready     = resetn && (count_q < CW'(DEPTH));
    assign c_reg         = c_reg_q;
    assign c_writedatain = c_data_q;
    assign c_we          = c_we_q;
    assign fifo_count    = count_q;

    // Issue select: ALU first, then FIFO head, then direct bypass of a fresh slow result
    always_comb begin
        alu_iss     = alu_we && (alu_reg != '0);
        mem_acc     = mem_valid && mem_ready;
        fifo_ne     = (count_q != '0);
        pop         = !alu_iss && fifo_ne;
        bypass      = !alu_iss && !fifo_ne && mem_acc && (mem_reg != '0);
        push        = mem_acc && (mem_reg != '0) && !bypass;

        fifo_reg_d  = fifo_reg_q;
        fifo_data_d = fifo_data_q;
        fifo_vld_d  = fifo_vld_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        count_d     = count_q;
        c_reg_d     = c_reg_q;
        c_data_d    = c_data_q;
        c_we_d      = 1'b0;

        if (alu_iss) begin
            c_we_d   = 1'b1;
            c_reg_d  = alu_reg;
            c_data_d = alu_data;
        end else if (pop) begin
            c_we_d = fifo_vld_q[rd_ptr_q];
            if (fifo_vld_q[rd_ptr_q]) begin
                c_reg_d  = fifo_reg_q[rd_ptr_q];
                c_data_d = fifo_data_q[rd_ptr_q];
            end
        end else if (bypass) begin
            c_we_d   = 1'b1;
            c_reg_d  = mem_reg;
            c_data_d = mem_data;
        end

        // A newer ALU write supersedes any buffered write to the same register
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (alu_iss && (fifo_reg_q[i] == alu_reg)) begin
                fifo_vld_d[i] = 1'b0;
            end
        end

        if (pop) begin
            fifo_vld_d[rd_ptr_q] = 1'b0;
            rd_ptr_d             = rd_ptr_q + LOG2DEPTH'(1);
        end

        if (push) begin
            fifo_reg_d[wr_ptr_q]  = mem_reg;
            fifo_data_d[wr_ptr_q] = mem_data;
            fifo_vld_d[wr_ptr_q]  = !(alu_iss && (mem_reg == alu_reg));
            wr_ptr_d              = wr_ptr_q + LOG2DEPTH'(1);
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= '0;
                fifo_data_q[i] <= '0;
            end
            fifo_vld_q <= '0;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
            c_reg_q    <= '0;
            c_data_q   <= '0;
            c_we_q     <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                fifo_reg_q[i]  <= fifo_reg_d[i];
                fifo_data_q[i] <= fifo_data_d[i];
            end
            fifo_vld_q <= fifo_vld_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
            c_reg_q    <= c_reg_d;
            c_data_q   <= c_data_d;
            c_we_q     <= c_we_d;
        end
    end

    // Pending status from registered state only; popped slots have their valid bit cleared
    always_comb begin
        a_pending = 1'b0;
        b_pending = 1'b0;
        if (c_we_q && (c_reg_q == a_reg)) a_pending = 1'b1;
        if (c_we_q && (c_reg_q == b_reg)) b_pending = 1'b1;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            if (fifo_vld_q[i] && (fifo_reg_q[i] == a_reg)) a_pending = 1'b1;
            if (fifo_vld_q[i] && (fifo_reg_q[i] == b_reg)) b_pending = 1'b1;
        end
        if (a_reg == '0) a_pending = 1'b0;
        if (b_reg == '0) b_pending = 1'b0;
    end

endmodule

// File: tb/tb_reg_writeback_arb.sv
// Directed bench for reg_writeback_arb: queue-based reference model checked every cycle,
// plus literal expectations for the key scenarios.
module tb_reg_writeback_arb;

    localparam int unsigned DEPTH = 4;

    logic        clk = 1'b0;
    logic        resetn;
    logic        alu_we;
    logic [4:0]  alu_reg;
    logic [31:0] alu_data;
    logic        mem_valid;
    logic [4:0]  mem_reg;
    logic [31:0] mem_data;
    logic        mem_ready;
    logic [4:0]  c_reg;
    logic [31:0] c_writedatain;
    logic        c_we;
    logic [4:0]  a_reg, b_reg;
    logic        a_pending, b_pending;
    logic [2:0]  fifo_count;

    reg_writeback_arb dut (
        .clk(clk), .resetn(resetn),
        .alu_we(alu_we), .alu_reg(alu_reg), .alu_data(alu_data),
        .mem_valid(mem_valid), .mem_reg(mem_reg), .mem_data(mem_data), .mem_ready(mem_ready),
        .c_reg(c_reg), .c_writedatain(c_writedatain), .c_we(c_we),
        .a_reg(a_reg), .b_reg(b_reg), .a_pending(a_pending), .b_pending(b_pending),
        .fifo_count(fifo_count)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: program-ordered queue of buffered writes plus the write-port state
    typedef struct { logic [4:0] r; logic [31:0] d; bit v; } ent_t;
    ent_t        mq[$];
    bit          m_we = 1'b0;
    logic [4:0]  m_reg = '0;
    logic [31:0] m_data = '0;

    function automatic bit m_pend(input logic [4:0] r);
        if (r == 0) return 1'b0;
        if (m_we && m_reg == r) return 1'b1;
        foreach (mq[i]) if (mq[i].v && mq[i].r == r) return 1'b1;
        return 1'b0;
    endfunction

    always @(posedge clk) begin
        bit   acc;
        ent_t e;
        if (!resetn) begin
            mq.delete();
            m_we = 0; m_reg = '0; m_data = '0;
        end else begin
            acc = mem_valid && (mq.size() < DEPTH);
            if (alu_we && alu_reg != 0) begin
                m_we = 1; m_reg = alu_reg; m_data = alu_data;
                foreach (mq[i]) if (mq[i].r == alu_reg) mq[i].v = 0;
                if (acc && mem_reg != 0) mq.push_back('{mem_reg, mem_data, mem_reg != alu_reg});
            end else if (mq.size() > 0) begin
                e = mq.pop_front();
                m_we = e.v;
                if (e.v) begin m_reg = e.r; m_data = e.d; end
                if (acc && mem_reg != 0) mq.push_back('{mem_reg, mem_data, 1'b1});
            end else if (acc && mem_reg != 0) begin
                m_we = 1; m_reg = mem_reg; m_data = mem_data;
            end else begin
                m_we = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            chk("c_we", 32'(c_we), 32'(m_we));
            if (m_we) begin
                chk("c_reg", 32'(c_reg), 32'(m_reg));
                chk("c_data", c_writedatain, m_data);
            end
            chk("fifo_count", 32'(fifo_count), 32'(mq.size()));
            chk("mem_ready", 32'(mem_ready), 32'(resetn && mq.size() < DEPTH));
            chk("a_pending", 32'(a_pending), 32'(m_pend(a_reg)));
            chk("b_pending", 32'(b_pending), 32'(m_pend(b_reg)));
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic idle_in();
        alu_we = 0; alu_reg = '0; alu_data = '0;
        mem_valid = 0; mem_reg = '0; mem_data = '0;
    endtask

    initial begin
        resetn = 0; a_reg = '0; b_reg = '0;
        idle_in();
        step();
        chk_en = 1;
        step();
        chk("rst_c_we", 32'(c_we), 0);
        chk("rst_c_reg", 32'(c_reg), 0);
        chk("rst_c_data", c_writedatain, 0);
        chk("rst_count", 32'(fifo_count), 0);
        chk("rst_ready", 32'(mem_ready), 0);
        resetn = 1;

        // Single ALU write, latency one
        alu_we = 1; alu_reg = 5'd3; alu_data = 32'hA5;
        step();
        chk("alu_we", 32'(c_we), 1);
        chk("alu_reg", 32'(c_reg), 3);
        chk("alu_data", c_writedatain, 32'hA5);
        idle_in();
        step();
        chk("alu_we_off", 32'(c_we), 0);

        // Fill FIFO while ALU busy; mem_valid held on reg 5 until accepted
        for (int i = 1; i <= 5; i++) begin
            alu_we = 1; alu_reg = 5'(20 + i); alu_data = 32'(i);
            mem_valid = 1; mem_reg = 5'(i); mem_data = 32'h100 + 32'(i);
            step();
        end
        chk("fill_count", 32'(fifo_count), 4);
        chk("fill_ready", 32'(mem_ready), 0);
        alu_we = 0;
        step();
        chk("drain1_reg", 32'(c_reg), 1);
        chk("drain1_cnt", 32'(fifo_count), 3);
        step();
        chk("drain2_reg", 32'(c_reg), 2);
        chk("drain2_cnt", 32'(fifo_count), 3);
        mem_valid = 0;
        for (int i = 3; i <= 5; i++) begin
            step();
            chk("drain_reg", 32'(c_reg), 32'(i));
            chk("drain_data", c_writedatain, 32'h100 + 32'(i));
        end
        step();
        chk("drain_empty", 32'(fifo_count), 0);

        // Kill of a buffered write by a newer ALU write
        a_reg = 5'd7;
        alu_we = 1; alu_reg = 5'd9; alu_data = 32'h99;
        mem_valid = 1; mem_reg = 5'd7; mem_data = 32'h11;
        step();
        chk("kill_pend0", 32'(a_pending), 1);
        chk("kill_cnt0", 32'(fifo_count), 1);
        mem_valid = 0; alu_reg = 5'd7; alu_data = 32'h22;
        step();
        chk("kill_we", 32'(c_we), 1);
        chk("kill_data", c_writedatain, 32'h22);
        chk("kill_pend1", 32'(a_pending), 1);
        idle_in();
        step();
        chk("kill_drain_we", 32'(c_we), 0);
        chk("kill_drain_cnt", 32'(fifo_count), 0);
        chk("kill_pend2", 32'(a_pending), 0);
        step();

        // Register 0 is never written
        alu_we = 1; alu_reg = '0; alu_data = 32'hFFFF;
        mem_valid = 1; mem_reg = '0; mem_data = 32'hFFFF;
        step();
        chk("r0_we", 32'(c_we), 0);
        chk("r0_cnt", 32'(fifo_count), 0);
        idle_in();

        // Same-cycle ALU issue and slow accept to one register: enqueued killed
        alu_we = 1; alu_reg = 5'd9; mem_valid = 1; mem_reg = 5'd5; mem_data = 32'h55;
        step();
        alu_reg = 5'd5; alu_data = 32'h66; mem_data = 32'h77;
        step();
        idle_in();
        step();
        step();
        chk("dual_kill_we", 32'(c_we), 0);
        step();

        // Fill to three then reset for one cycle
        a_reg = 5'd11; b_reg = 5'd12;
        for (int i = 0; i < 3; i++) begin
            alu_we = 1; alu_reg = 5'(20 + i); alu_data = 32'(i);
            mem_valid = 1; mem_reg = 5'(11 + i); mem_data = 32'h200 + 32'(i);
            step();
        end
        chk("pre_rst_cnt", 32'(fifo_count), 3);
        chk("pre_rst_bpend", 32'(b_pending), 1);
        idle_in();
        resetn = 0;
        step();
        resetn = 1;
        #1;
        chk("post_rst_cnt", 32'(fifo_count), 0);
        chk("post_rst_we", 32'(c_we), 0);
        chk("post_rst_apend", 32'(a_pending), 0);
        chk("post_rst_bpend", 32'(b_pending), 0);
        chk("post_rst_ready", 32'(mem_ready), 1);

        // Mixed traffic over a small register range, checked by the model
        for (int i = 0; i < 60; i++) begin
            alu_we = 1'($urandom_range(0, 1)); alu_reg = 5'($urandom_range(0, 7));
            alu_data = $urandom;
            mem_valid = 1'($urandom_range(0, 1)); mem_reg = 5'($urandom_range(0, 7));
            mem_data = $urandom;
            a_reg = 5'($urandom_range(0, 7)); b_reg = 5'($urandom_range(0, 7));
            step();
        end
        idle_in();
        repeat (6) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
